// File: rtl/tran_ascii_pkg.sv
// rtl/tran_ascii_pkg.sv - shared scan-code constants for the scan-code to ASCII translator
package tran_ascii_pkg;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] ASCII_NONE = 8'h00;

  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/tran_ascii_lut.sv
// rtl/tran_ascii_lut.sv - combinational Set-2 make code to ASCII table
// Shifted entries cover letters (uppercase) and the digit row symbols only.
module tran_ascii_lut
  import tran_ascii_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_NONE;
    unique case (code)
      8'h1C: ascii = shift ? 8'h41 : 8'h61;
      8'h32: ascii = shift ? 8'h42 : 8'h62;
      8'h21: ascii = shift ? 8'h43 : 8'h63;
      8'h23: ascii = shift ? 8'h44 : 8'h64;
      8'h24: ascii = shift ? 8'h45 : 8'h65;
      8'h2B: ascii = shift ? 8'h46 : 8'h66;
      8'h34: ascii = shift ? 8'h47 : 8'h67;
      8'h33: ascii = shift ? 8'h48 : 8'h68;
      8'h43: ascii = shift ? 8'h49 : 8'h69;
      8'h3B: ascii = shift ? 8'h4A : 8'h6A;
      8'h42: ascii = shift ? 8'h4B : 8'h6B;
      8'h4B: ascii = shift ? 8'h4C : 8'h6C;
      8'h3A: ascii = shift ? 8'h4D : 8'h6D;
      8'h31: ascii = shift ? 8'h4E : 8'h6E;
      8'h44: ascii = shift ? 8'h4F : 8'h6F;
      8'h4D: ascii = shift ? 8'h50 : 8'h70;
      8'h15: ascii = shift ? 8'h51 : 8'h71;
      8'h2D: ascii = shift ? 8'h52 : 8'h72;
      8'h1B: ascii = shift ? 8'h53 : 8'h73;
      8'h2C: ascii = shift ? 8'h54 : 8'h74;
      8'h3C: ascii = shift ? 8'h55 : 8'h75;
      8'h2A: ascii = shift ? 8'h56 : 8'h76;
      8'h1D: ascii = shift ? 8'h57 : 8'h77;
      8'h22: ascii = shift ? 8'h58 : 8'h78;
      8'h35: ascii = shift ? 8'h59 : 8'h79;
      8'h1A: ascii = shift ? 8'h5A : 8'h7A;
      // Digit row: shifted values follow the US layout symbols
      8'h45: ascii = shift ? 8'h29 : 8'h30;
      8'h16: ascii = shift ? 8'h21 : 8'h31;
      8'h1E: ascii = shift ? 8'h40 : 8'h32;
      8'h26: ascii = shift ? 8'h23 : 8'h33;
      8'h25: ascii = shift ? 8'h24 : 8'h34;
      8'h2E: ascii = shift ? 8'h25 : 8'h35;
      8'h36: ascii = shift ? 8'h5E : 8'h36;
      8'h3D: ascii = shift ? 8'h26 : 8'h37;
      8'h3E: ascii = shift ? 8'h2A : 8'h38;
      8'h46: ascii = shift ? 8'h28 : 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      8'h66: ascii = 8'h08;
      default: ascii = ASCII_NONE;
    endcase
  end

endmodule

// File: rtl/tran_ascii.sv
// rtl/tran_ascii.sv - registered scan-code to ASCII translator top
// Define TRAN_ASCII_SHIFT_EN to compile in shift-key tracking.
module tran_ascii
  import tran_ascii_pkg::*;
(
  input  logic       clock,
  input  logic       clrn,
  input  logic [7:0] scanCode,
  output logic [7:0] asciiCode
);

  logic [7:0] ascii_d;
  logic [7:0] ascii_q;
  logic       shift_en;

`ifdef TRAN_ASCII_SHIFT_EN
  logic       shift_d;
  logic       shift_q;
  logic [7:0] prev_d;
  logic [7:0] prev_q;

  // Only a change of byte is an event, so typematic repeats cannot flip shift.
  always_comb begin
    prev_d  = prev_q;
    shift_d = shift_q;
    if (scanCode != prev_q) begin
      prev_d = scanCode;
      if (is_shift_code(scanCode)) begin
        shift_d = (prev_q != SC_BREAK);
      end
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      prev_q  <= 8'h00;
      shift_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      shift_q <= shift_d;
    end
  end

  assign shift_en = shift_q;
`else
  assign shift_en = 1'b0;
`endif

  tran_ascii_lut u_lut (
    .code  (scanCode),
    .shift (shift_en),
    .ascii (ascii_d)
  );

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      ascii_q <= ASCII_NONE;
    end else begin
      ascii_q <= ascii_d;
    end
  end

  assign asciiCode = ascii_q;

endmodule

// File: tb/tb_tran_ascii.sv
// tb/tb_tran_ascii.sv - directed self-checking bench for tran_ascii
module tb_tran_ascii;

  logic       clock;
  logic       clrn;
  logic [7:0] scanCode;
  logic [7:0] asciiCode;

  int checks   = 0;
  int failures = 0;

  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] digit_sym [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};

  logic [7:0] m_prev;
  logic       m_shift;
  logic [7:0] exp_next;

  tran_ascii dut (
    .clock     (clock),
    .clrn      (clrn),
    .scanCode  (scanCode),
    .asciiCode (asciiCode)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] c, input logic sh);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == c) r = sh ? (8'h41 + 8'(i)) : (8'h61 + 8'(i));
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == c) r = sh ? digit_sym[i] : (8'h30 + 8'(i));
    if (c == 8'h29) r = 8'h20;
    if (c == 8'h5A) r = 8'h0D;
    if (c == 8'h66) r = 8'h08;
    return r;
  endfunction

  // Drive one byte, advance one edge, and leave the model's expectation in exp_next.
  task automatic apply(input logic [7:0] c);
    exp_next = model(c, m_shift);
`ifdef TRAN_ASCII_SHIFT_EN
    if (c != m_prev) begin
      if (c == 8'h12 || c == 8'h59) m_shift = (m_prev != 8'hF0);
      m_prev = c;
    end
`endif
    scanCode = c;
    @(posedge clock);
    #1;
  endtask

  initial begin
    clrn     = 1'b0;
    scanCode = 8'h1C;
    m_prev   = 8'h00;
    m_shift  = 1'b0;
    #1;
    check_eq("reset_t0", asciiCode, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_eq("reset_held", asciiCode, 8'h00);
    end
    clrn = 1'b1;
    apply(8'h1C);
    check_eq("reset_release", asciiCode, 8'h61);

    apply(8'h1C); check_eq("seq_1C",  asciiCode, 8'h61);
    apply(8'hF0); check_eq("seq_F0",  asciiCode, 8'h00);
    apply(8'h1C); check_eq("seq_1C_b", asciiCode, 8'h61);
    apply(8'h1B); check_eq("seq_1B",  asciiCode, 8'h73);
    apply(8'h1B); check_eq("hold_1B", asciiCode, 8'h73);

    apply(8'h29); check_eq("space", asciiCode, 8'h20);
    apply(8'h5A); check_eq("enter", asciiCode, 8'h0D);
    apply(8'h66); check_eq("bksp",  asciiCode, 8'h08);
    apply(8'h45); check_eq("dig0",  asciiCode, 8'h30);
    apply(8'h46); check_eq("dig9",  asciiCode, 8'h39);
    apply(8'hE0); check_eq("ext",   asciiCode, 8'h00);
    apply(8'hFF); check_eq("ff",    asciiCode, 8'h00);
    apply(8'h00); check_eq("zero",  asciiCode, 8'h00);

    for (int c = 0; c < 256; c++) begin
      apply(8'(c));
      check_eq($sformatf("sweep_%02h", c), asciiCode, exp_next);
    end

`ifdef TRAN_ASCII_SHIFT_EN
    apply(8'hF0);
    apply(8'h12);
    apply(8'h00);
    apply(8'h12); check_eq("sh_lshift", asciiCode, 8'h00);
    apply(8'h1C); check_eq("sh_upper_a", asciiCode, 8'h41);
    apply(8'h1C); check_eq("sh_repeat", asciiCode, 8'h41);
    apply(8'hF0);
    apply(8'h12);
    apply(8'h1C); check_eq("sh_release", asciiCode, 8'h61);
    apply(8'h59);
    apply(8'h16); check_eq("sh_rshift_1", asciiCode, 8'h21);
    apply(8'h36); check_eq("sh_caret", asciiCode, 8'h5E);
    apply(8'h29); check_eq("sh_space", asciiCode, 8'h20);
`endif

    apply(8'h59);
    apply(8'h1B);
`ifdef TRAN_ASCII_SHIFT_EN
    check_eq("pre_async", asciiCode, 8'h53);
`else
    check_eq("pre_async", asciiCode, 8'h73);
`endif
    #2;
    clrn = 1'b0;
    #1;
    check_eq("async_clear", asciiCode, 8'h00);
    @(posedge clock);
    #1;
    check_eq("async_held", asciiCode, 8'h00);
    clrn    = 1'b1;
    m_prev  = 8'h00;
    m_shift = 1'b0;
    apply(8'h1B);
    check_eq("post_async", asciiCode, 8'h73);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
